morse_key_timer: RTL and testbench
==================================

Name: morse_key_timer

Overview:
- Front-end stage directly upstream of the Morse letter-decoder FSM.
- Converts a raw, bouncing telegraph key/button into the decoder's 2-bit symbol stream: 01 dot, 10 dash, 11 send (end of letter), 00 idle.
- Flow: synchronize and debounce the key, measure press length to pick dot or dash, measure release gap to emit send.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before the debounced level changes.
- DASH_CYCLES, 200: press duration (cycles) at or above which a press is a dash; below is a dot.
- GAP_CYCLES, 600: released duration (cycles) after the last symbol that triggers a send.
- CNT_W, 24: width of the duration counters; must hold max(DASH_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset), released synchronously by the system.
- key_raw  input  1  raw key level, 1 = pressed, asynchronous to clk.
- symbol  output  2  one-cycle code to the decoder: 00 idle, 01 dot, 10 dash, 11 send.
- key_level  output  1  debounced key level.
- symbols_pending  output  3  symbols emitted since last send, saturating at 7.
- busy  output  1  high in PRESS or GAP states.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - symbol=00, key_level=0, symbols_pending=0, busy=0.
  - Synchronizer flops 0, all counters 0, state IDLE.
- Synchronizer: 2-flop chain on key_raw; key_sync is the second flop.
- Debounce:
  - Counter increments while key_sync != key_level and clears when they are equal.
  - When the count reaches DEBOUNCE_CYCLES-1 with a mismatch, key_level toggles on that edge and the counter clears.
  - Result: key_level changes exactly DEBOUNCE_CYCLES cycles after key_sync settles. Glitches shorter than that are ignored.
- rise/fall: one-cycle strobes derived from key_level versus its previous value.
- symbol is registered, defaults to 00 every cycle, and is never non-zero for two consecutive cycles.
- FSM states IDLE, PRESS, GAP:
  - IDLE, rise -> PRESS; duration counter := 1.
  - PRESS, each cycle: duration counter increments, saturating at all-ones.
  - PRESS, fall:
    - symbol := 10 if count >= DASH_CYCLES, else 01.
    - symbols_pending increments (saturating at 7).
    - Gap counter := 1; -> GAP.
  - GAP, each cycle key_level=0: gap counter increments.
  - GAP, gap counter reaches GAP_CYCLES: symbol := 11, symbols_pending := 0, -> IDLE.
  - GAP, rise before the threshold: -> PRESS; duration counter := 1, gap counter cleared, no send.
- A send is only ever issued from GAP, so it is always preceded by at least one dot or dash. Idle time in IDLE never produces 11.
- Boundaries:
  - Press of exactly DASH_CYCLES cycles = dash; DASH_CYCLES-1 = dot.
  - Rise in the same cycle the gap threshold is hit: send wins; the FSM goes to IDLE and takes the press on the next rise detection. Because key_level stays 1, IDLE treats key_level=1 as a press start, so the press is not lost.
  - Key held indefinitely: counter saturates; on release the press emits a dash.
  - Reset mid-press or mid-gap: pending symbols are discarded and no send is emitted.
- busy = (state != IDLE).
- Latency: from the key_raw edge to the symbol pulse is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the release edge.

Test Plan (DEBOUNCE_CYCLES=4, DASH_CYCLES=20, GAP_CYCLES=40):
1. Reset asserted mid-stream, key_raw=1 -> all outputs 0 immediately (asynchronous); after release, symbol stays 00 until a debounced press.
2. Clean press of 10 cycles then release -> exactly one symbol=01 pulse. After 40 released cycles, one symbol=11 pulse; symbols_pending goes 1 then 0.
3. Presses of 19 and 20 debounced cycles, separated by 10 released cycles -> 01 then 10, symbols_pending=2, then a single 11 after the gap; no 11 between the two presses.
4. Bouncing input: 3-cycle pulses of key_raw toggling for 30 cycles, then steady low -> key_level never rises, symbol stays 00, busy stays 0.
5. Long press of 2^CNT_W+100 cycles (or forced counter) -> a single 10 on release, no counter wrap to dot.
6. Press starting in the exact cycle the gap counter reaches 40 -> 11 emitted that cycle; the press then yields its own 01/10 and a later 11.

Source files
------------

// File: rtl/morse_key_timer_if.sv
// Symbol-stream bundle between the key front end and its neighbours.
//   key_raw         : raw key level from the outside world (1 = pressed)
//   symbol          : one-cycle code 00 idle, 01 dot, 10 dash, 11 send
//   key_level       : debounced key level
//   symbols_pending : dots/dashes emitted since the last send (saturates at 7)
//   busy            : timer is inside a press or a gap
// slave  = the timer, master = whoever drives the key and consumes symbols.
interface morse_key_timer_if;
    logic       key_raw;
    logic [1:0] symbol;
    logic       key_level;
    logic [2:0] symbols_pending;
    logic       busy;

    modport slave (
        input  key_raw,
        output symbol, key_level, symbols_pending, busy
    );
    modport master (
        output key_raw,
        input  symbol, key_level, symbols_pending, busy
    );
endinterface

// File: rtl/morse_key_timer.sv
// Morse key timer: synchronizes and debounces a raw telegraph key, times each
// press to classify dot/dash, and times the release gap to issue a send.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : morse_key_timer_if.slave (key_raw in; symbol, key_level,
//           symbols_pending, busy out)
module morse_key_timer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DASH_CYCLES     = 200,
    parameter int GAP_CYCLES      = 600,
    parameter int CNT_W           = 24
) (
    input  logic               clk,
    input  logic               reset,
    morse_key_timer_if.slave   bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic             key_level_q, level_prev_q;
    logic [CNT_W-1:0] dur_q, gap_q;
    logic [1:0]       symbol_q;
    logic [2:0]       pend_q;

    logic             fall;
    logic [1:0]       press_sym_d;

    assign fall        = level_prev_q & ~key_level_q;
    assign press_sym_d = (dur_q >= CNT_W'(DASH_CYCLES)) ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            key_level_q  <= 1'b0;
            level_prev_q <= 1'b0;
            dur_q        <= '0;
            gap_q        <= '0;
            symbol_q     <= 2'b00;
            pend_q       <= 3'd0;
        end else begin
            sync1_q      <= bus.key_raw;
            sync2_q      <= sync1_q;
            level_prev_q <= key_level_q;

            // Level flips only after DEBOUNCE_CYCLES consecutive mismatching
            // samples; any agreeing sample restarts the count.
            if (sync2_q != key_level_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_level_q <= sync2_q;
                    db_cnt_q    <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end

            symbol_q <= 2'b00;

            case (state_q)
                // Level rather than rise starts a press, so a rise that
                // coincided with a send in GAP is still picked up here.
                IDLE: begin
                    if (key_level_q) begin
                        state_q <= PRESS;
                        dur_q   <= CNT_W'(1);
                    end
                end
                PRESS: begin
                    if (fall) begin
                        symbol_q <= press_sym_d;
                        if (pend_q != 3'd7) pend_q <= pend_q + 3'd1;
                        gap_q    <= CNT_W'(1);
                        state_q  <= GAP;
                    end else if (dur_q != '1) begin
                        dur_q <= dur_q + 1'b1;
                    end
                end
                GAP: begin
                    // Threshold is tested first: send wins over a new press.
                    if (gap_q >= CNT_W'(GAP_CYCLES)) begin
                        symbol_q <= 2'b11;
                        pend_q   <= 3'd0;
                        gap_q    <= '0;
                        state_q  <= IDLE;
                    end else if (key_level_q) begin
                        dur_q   <= CNT_W'(1);
                        gap_q   <= '0;
                        state_q <= PRESS;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.symbol          = symbol_q;
    assign bus.key_level       = key_level_q;
    assign bus.symbols_pending = pend_q;
    assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_morse_key_timer.sv
module tb_morse_key_timer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    morse_key_timer_if bus ();

    // CNT_W=6 saturates at 63, so a 75-cycle press would wrap to 11 (a dot)
    // without saturation.
    morse_key_timer #(
        .DEBOUNCE_CYCLES(4), .DASH_CYCLES(20), .GAP_CYCLES(40), .CNT_W(6)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0] sym;
        logic [2:0] pend;
    } exp_t;

    typedef struct {
        int         hi;
        int         lo;
        logic [1:0] sym;
        logic [2:0] pend;
        bit         send;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard consumer: every non-idle symbol pops one expectation.
    logic [1:0] prev_sym = 2'b00;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            prev_sym = 2'b00;
        end else begin
            if (bus.symbol != 2'b00) begin
                chk("sym_not_back_to_back", {30'd0, prev_sym}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_symbol", {30'd0, bus.symbol}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("symbol", {30'd0, bus.symbol}, {30'd0, e.sym});
                    chk("pending", {29'd0, bus.symbols_pending}, {29'd0, e.pend});
                    chk("busy_at_symbol", {31'd0, bus.busy}, {31'd0, (e.sym != 2'b11)});
                end
            end
            prev_sym = bus.symbol;
        end
    end

    initial begin
        vec_t tbl[7];
        bit   found;

        tbl[0] = '{hi: 10, lo: 60, sym: 2'b01, pend: 3'd1, send: 1'b1};
        tbl[1] = '{hi: 19, lo: 10, sym: 2'b01, pend: 3'd1, send: 1'b0};
        tbl[2] = '{hi: 20, lo: 60, sym: 2'b10, pend: 3'd2, send: 1'b1};
        tbl[3] = '{hi: 75, lo: 60, sym: 2'b10, pend: 3'd1, send: 1'b1};
        tbl[4] = '{hi:  5, lo:  8, sym: 2'b01, pend: 3'd1, send: 1'b0};
        tbl[5] = '{hi: 30, lo:  8, sym: 2'b10, pend: 3'd2, send: 1'b0};
        tbl[6] = '{hi:  6, lo: 60, sym: 2'b01, pend: 3'd3, send: 1'b1};

        // Reset state
        rst_n = 1'b0;
        bus.key_raw = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_symbol",  {30'd0, bus.symbol}, 32'd0);
        chk("rst_level",   {31'd0, bus.key_level}, 32'd0);
        chk("rst_pending", {29'd0, bus.symbols_pending}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;

        // Reset mid-press: outputs clear asynchronously, nothing emitted later
        bus.key_raw = 1'b1;
        repeat (15) @(negedge clk);
        chk("midpress_busy",  {31'd0, bus.busy}, 32'd1);
        chk("midpress_level", {31'd0, bus.key_level}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_level", {31'd0, bus.key_level}, 32'd0);
        chk("async_rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("async_rst_sym",   {30'd0, bus.symbol}, 32'd0);
        chk("async_rst_pend",  {29'd0, bus.symbols_pending}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.key_raw = 1'b0;
        repeat (60) @(negedge clk);
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_rst_pend", {29'd0, bus.symbols_pending}, 32'd0);

        // Table-driven presses and gaps
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{sym: tbl[i].sym, pend: tbl[i].pend});
            if (tbl[i].send) sb.push_back('{sym: 2'b11, pend: 3'd0});
            bus.key_raw = 1'b1;
            repeat (tbl[i].hi) @(negedge clk);
            bus.key_raw = 1'b0;
            repeat (tbl[i].lo) @(negedge clk);
        end
        chk("table_drained", sb.size(), 32'd0);
        chk("table_idle", {31'd0, bus.busy}, 32'd0);

        // Bouncing key: 3-cycle pulses never survive a 4-sample debounce
        for (int c = 0; c < 50; c++) begin
            bus.key_raw = (c < 30) ? ((c / 3) % 2 == 0) : 1'b0;
            @(negedge clk);
            chk("bounce_level", {31'd0, bus.key_level}, 32'd0);
            chk("bounce_busy",  {31'd0, bus.busy}, 32'd0);
            chk("bounce_sym",   {30'd0, bus.symbol}, 32'd0);
        end

        // Debounced rise lands exactly when the gap counter hits threshold
        sb.push_back('{sym: 2'b01, pend: 3'd1});
        sb.push_back('{sym: 2'b11, pend: 3'd0});
        sb.push_back('{sym: 2'b01, pend: 3'd1});
        sb.push_back('{sym: 2'b11, pend: 3'd0});
        bus.key_raw = 1'b1;
        repeat (10) @(negedge clk);
        bus.key_raw = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.symbol == 2'b01) found = 1'b1;
        end
        chk("t6_dot_seen", {31'd0, found}, 32'd1);
        // Dot visible after edge f+1; raw sampled at f+35 gives level at f+40,
        // and the send is registered at f+41.
        repeat (33) @(negedge clk);
        bus.key_raw = 1'b1;
        repeat (7) @(negedge clk);
        chk("t6_send_cycle", {30'd0, bus.symbol}, 32'd3);
        chk("t6_level_high", {31'd0, bus.key_level}, 32'd1);
        chk("t6_idle_at_send", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("t6_press_taken", {31'd0, bus.busy}, 32'd1);
        repeat (2) @(negedge clk);
        bus.key_raw = 1'b0;
        repeat (100) @(negedge clk);
        chk("final_drained", sb.size(), 32'd0);
        chk("final_idle", {31'd0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
